multicycle_control_unit: RTL and testbench

Moore-FSM control unit for the multicycle RV32I datapath, the next generation of the single-cycle combinational control unit. It sequences each instruction through fetch, decode, execute, memory and writeback, producing per-cycle datapath strobes and mux selects. It stalls on a memory-ready handshake and traps to an error state on memory timeout. It sits between the instruction register / ALU Zero flag and the shared-memory multicycle datapath.

---
 rtl/multicycle_control_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Moore-FSM control unit for the multicycle RV32I datapath with memory-ready stalls and timeout trap.
// Optional feature: define CU_BRANCH_NE_EN to take branches on ~Zero when funct3=001 (bne).
module multicycle_control_unit #(
    parameter int ALUC_W   = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        Op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              Zero,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              RegWrite,
    output logic              illegal,
    output logic              mem_err,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BRCH = 7'b1100011;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_err_q;

    logic       pc_update, branch, taken, mem_wait;
    logic       mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;
    logic [1:0] alu_op;
    logic [2:0] alu_ctl;
    logic       unused_bits;

    assign unused_bits = ^{funct7[6], funct7[4:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_q | (state_d == S_ERROR);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_wait      = 1'b0;
        alu_op        = 2'b00;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
                mem_wait     = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BRCH:      state_d = S_BEQ;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc   = 1'b1;
                mem_wait = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                mem_wait      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase

        // The stall that would reach WAIT_MAX not-ready cycles traps instead of waiting again.
        if (mem_wait && !mem_ready && (WAIT_MAX != 0) && (int'(wait_q) + 1 == WAIT_MAX))
            state_d = S_ERROR;

        if ((state_d != state_q) || mem_ready || !mem_wait) wait_d = '0;
        else                                                 wait_d = wait_q + 8'd1;
    end

    always_comb begin
`ifdef CU_BRANCH_NE_EN
        taken = (funct3 == 3'b001) ? ~Zero : Zero;
`else
        taken = Zero;
`endif
    end

    always_comb begin
        unique case (alu_op)
            2'b00: alu_ctl = 3'b000;
            2'b01: alu_ctl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_ctl = (Op[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctl = 3'b101;
                    3'b110:  alu_ctl = 3'b011;
                    3'b111:  alu_ctl = 3'b010;
                    default: alu_ctl = 3'b000;
                endcase
            end
            default: alu_ctl = 3'b000;
        endcase
        ALUControl      = '0;
        ALUControl[2:0] = alu_ctl;
    end

    always_comb begin
        case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BRCH: ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Strobes are masked while reset is held; the state register already shows FETCH.
    assign PCWrite  = ~rst & (pc_update | (branch & taken));
    assign IRWrite  = ~rst & ir_write_raw;
    assign MemWrite = ~rst & mem_write_raw;
    assign RegWrite = ~rst & reg_write_raw;
    assign illegal  = ~rst & illegal_raw;
    assign mem_err  = mem_err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table, corner sequences, random vs route model.
module tb_multicycle_control_unit;

    localparam int ALUC_W   = 3;
    localparam int WAIT_MAX = 15;

    logic              clk, rst;
    logic [6:0]        Op, funct7;
    logic [2:0]        funct3;
    logic              Zero, mem_ready;
    logic              PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, mem_err;
    logic [1:0]        ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [ALUC_W-1:0] ALUControl;
    logic [3:0]        state;

    multicycle_control_unit #(.ALUC_W(ALUC_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal(illegal),
        .mem_err(mem_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-state output table taken straight from the state descriptions.
    typedef struct {
        logic       adr, mw, ir;
        logic [1:0] rsrc, asrc, bsrc, aluop;
        logic       rw, pcu, br;
    } row_t;
    row_t tbl [12];

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        case (op)
            7'h23:   return 2'b01;
            7'h63:   return 2'b10;
            7'h6F:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input logic [1:0] aluop, input logic [6:0] op,
                                           input logic [2:0] f3, input logic [6:0] f7);
        if (aluop == 2'b01) return 3'b001;
        if (aluop != 2'b10) return 3'b000;
        case (f3)
            3'd0:    return (op[5] && f7[5]) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [21:0] model_out(input int s, input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic z, input logic rdy);
        row_t r;
        logic taken, pcw, irw;
        r     = tbl[s];
        taken = z;
`ifdef CU_BRANCH_NE_EN
        if (f3 == 3'b001) taken = ~z;
`endif
        irw = r.ir & rdy;
        pcw = r.pcu | irw | (r.br & taken);
        return {pcw, r.adr, r.mw, irw, r.rsrc, r.asrc, r.bsrc, exp_imm(op),
                exp_alu(r.aluop, op, f3, f7), r.rw, (s == 1) && !is_legal(op), s == 11, 4'(s)};
    endfunction

    logic [21:0] act_vec;
    assign act_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                      ALUControl[2:0], RegWrite, illegal, mem_err, state};

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zero;
        int         probe, cycles;
        logic [2:0] alu;
        logic       pcw;
        logic [1:0] imm;
        int         rw, mw, ill;
    } vec_t;
    vec_t vecs[$];

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Random-phase reference: each instruction is a list of states visited after DECODE.
    int m_state, m_wait;
    int route[$];

    task automatic model_step(input logic [6:0] op, input logic rdy);
        if (m_state == 11) return;
        if ((m_state inside {0, 3, 5}) && !rdy) begin
            m_wait++;
            if (m_wait == WAIT_MAX) m_state = 11;
            return;
        end
        m_wait = 0;
        if (m_state == 0) begin
            m_state = 1;
            return;
        end
        if (m_state == 1) begin
            case (op)
                7'h03:   route = '{2, 3, 4};
                7'h23:   route = '{2, 5};
                7'h33:   route = '{6, 7};
                7'h13:   route = '{8, 7};
                7'h6F:   route = '{9, 7};
                7'h63:   route = '{10};
                default: route = {};
            endcase
        end
        m_state = (route.size() != 0) ? route.pop_front() : 0;
    endtask

    initial begin
        logic bne_pcw;
        logic [3:0] lw_seq [5];
        int rw_cnt, mw_cnt, ill_cnt, cycles, stall_left, n_fetch;
        logic [2:0] p_alu;
        logic p_pcw, adr_ok, imm_ok;
        logic [1:0] p_imm;

        tbl[0]  = '{0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0};
        tbl[5]  = '{1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 1};
        tbl[11] = '{0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0};

`ifdef CU_BRANCH_NE_EN
        bne_pcw = 1'b1;
`else
        bne_pcw = 1'b0;
`endif
        //                name        op     f3    f7    z  prb cyc alu    pcw imm   rw mw ill
        vecs.push_back('{"lw",       7'h03, 3'd2, 7'h00, 0, 2, 5, 3'b000, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"sw",       7'h23, 3'd2, 7'h00, 0, 2, 4, 3'b000, 0, 2'b01, 0, 1, 0});
        vecs.push_back('{"r_sub",    7'h33, 3'd0, 7'h20, 0, 2, 4, 3'b001, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"r_add",    7'h33, 3'd0, 7'h00, 0, 2, 4, 3'b000, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"r_and",    7'h33, 3'd7, 7'h00, 0, 2, 4, 3'b010, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"r_or",     7'h33, 3'd6, 7'h00, 0, 2, 4, 3'b011, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"r_slt",    7'h33, 3'd2, 7'h00, 0, 2, 4, 3'b101, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"r_f3_1",   7'h33, 3'd1, 7'h20, 0, 2, 4, 3'b000, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"i_addi",   7'h13, 3'd0, 7'h20, 0, 2, 4, 3'b000, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"i_slti",   7'h13, 3'd2, 7'h00, 0, 2, 4, 3'b101, 0, 2'b00, 1, 0, 0});
        vecs.push_back('{"jal",      7'h6F, 3'd0, 7'h00, 0, 2, 4, 3'b000, 1, 2'b11, 1, 0, 0});
        vecs.push_back('{"beq_z1",   7'h63, 3'd0, 7'h00, 1, 2, 3, 3'b001, 1, 2'b10, 0, 0, 0});
        vecs.push_back('{"beq_z0",   7'h63, 3'd0, 7'h00, 0, 2, 3, 3'b001, 0, 2'b10, 0, 0, 0});
        vecs.push_back('{"bne_z0",   7'h63, 3'd1, 7'h00, 0, 2, 3, 3'b001, bne_pcw, 2'b10, 0, 0, 0});
        vecs.push_back('{"illegal",  7'h7F, 3'd0, 7'h00, 0, 1, 2, 3'b000, 0, 2'b00, 0, 0, 1});

        // Reset state: strobes forced low even with mem_ready=1, FETCH selects visible.
        rst = 1'b1; Op = 7'h03; funct3 = 3'd0; funct7 = 7'h00; Zero = 1'b0; mem_ready = 1'b1;
        #3;
        check("rst_strobes", {PCWrite, IRWrite, RegWrite, MemWrite, illegal}, 5'b0);
        check("rst_state", {mem_err, state}, 5'h00);
        check("rst_selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, {1'b0, 2'b00, 2'b10, 2'b10, 3'b000});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // lw state walk 0,1,2,3,4,0 with MEMWB writeback.
        lw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        rw_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("lw_state%0d", i), state, lw_seq[i]);
            rw_cnt += int'(RegWrite);
            if (state == 4'd4) check("lw_memwb_rsrc", {RegWrite, ResultSrc, ImmSrc}, {1'b1, 2'b01, 2'b00});
            @(negedge clk);
        end
        #1;
        check("lw_back_fetch", state, 4'd0);
        check("lw_rw_count", rw_cnt, 1);

        for (int v = 0; v < vecs.size(); v++) begin
            Op = vecs[v].op; funct3 = vecs[v].f3; funct7 = vecs[v].f7;
            Zero = vecs[v].zero; mem_ready = 1'b1;
            rw_cnt = 0; mw_cnt = 0; ill_cnt = 0; cycles = 0;
            p_alu = 'x; p_pcw = 'x; p_imm = 'x;
            for (int c = 0; c < 12; c++) begin
                #1;
                rw_cnt  += int'(RegWrite);
                mw_cnt  += int'(MemWrite);
                ill_cnt += int'(illegal);
                if (c == vecs[v].probe) begin
                    p_alu = ALUControl[2:0]; p_pcw = PCWrite; p_imm = ImmSrc;
                end
                @(negedge clk);
                if (state == 4'd0) begin
                    cycles = c + 1;
                    break;
                end
            end
            check({vecs[v].name, "_cycles"}, cycles, vecs[v].cycles);
            check({vecs[v].name, "_alu"}, p_alu, vecs[v].alu);
            check({vecs[v].name, "_pcwrite"}, p_pcw, vecs[v].pcw);
            check({vecs[v].name, "_immsrc"}, p_imm, vecs[v].imm);
            check({vecs[v].name, "_regwrite_cnt"}, rw_cnt, vecs[v].rw);
            check({vecs[v].name, "_memwrite_cnt"}, mw_cnt, vecs[v].mw);
            check({vecs[v].name, "_illegal_cnt"}, ill_cnt, vecs[v].ill);
        end

        // sw with three not-ready cycles in MEMWRITE: four write cycles, then FETCH.
        Op = 7'h23; funct3 = 3'd2; stall_left = 3; mw_cnt = 0; adr_ok = 1'b1; imm_ok = 1'b1; cycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (state == 4'd5 && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else mem_ready = 1'b1;
            #1;
            if (state == 4'd5) begin
                mw_cnt += int'(MemWrite);
                adr_ok &= AdrSrc;
                imm_ok &= (ImmSrc == 2'b01);
            end
            @(negedge clk);
            if (state == 4'd0) begin
                cycles = c + 1;
                break;
            end
        end
        check("sw_stall_memwrite_cnt", mw_cnt, 4);
        check("sw_stall_adrsrc", adr_ok, 1'b1);
        check("sw_stall_immsrc", imm_ok, 1'b1);
        check("sw_stall_cycles", cycles, 7);

        // Reset mid-instruction aborts immediately; first cycle after release is FETCH.
        Op = 7'h03; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_pre_state", state, 4'd2);
        rst = 1'b1;
        #1;
        check("abort_state", state, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release_fetch", {state, IRWrite}, {4'd0, 1'b1});
        @(negedge clk);
        #1;
        check("abort_then_decode", state, 4'd1);
        do_reset();

        // Timeout in FETCH: 15 not-ready cycles, then sticky ERROR.
        Op = 7'h33; mem_ready = 1'b0; n_fetch = 0;
        for (int c = 0; c < 40; c++) begin
            if (state != 4'd0) break;
            n_fetch++;
            @(negedge clk);
        end
        check("timeout_fetch_cycles", n_fetch, WAIT_MAX);
        check("timeout_error", {state, mem_err}, {4'd11, 1'b1});
        mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("error_sticky", {state, mem_err}, {4'd11, 1'b1});
        check("error_strobes", {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc}, 5'b0);
        rst = 1'b1;
        #1;
        check("error_reset", {state, mem_err}, {4'd0, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        // Random instruction stream against the route model.
        m_state = 0; m_wait = 0; route = {};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_state == 0) begin
                case ($urandom_range(0, 6))
                    0: Op = 7'h03;
                    1: Op = 7'h23;
                    2: Op = 7'h33;
                    3: Op = 7'h13;
                    4: Op = 7'h6F;
                    5: Op = 7'h63;
                    default: Op = 7'($urandom);
                endcase
                funct3 = 3'($urandom);
                funct7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom);
            end
            Zero      = 1'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            check($sformatf("rand_cyc%0d", cyc), act_vec, model_out(m_state, Op, funct3, funct7, Zero, mem_ready));
            model_step(Op, mem_ready);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
